// File: rtl/t_flipflop_bank.sv
// WIDTH-bit bank of T cells with toggle, load, up-count and down-count modes.
// Define T_FLIPFLOP_BANK_CHANGED_EN to add the registered 'changed' output.

module t_flipflop_cell (
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic tog,
  input  logic ld,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) begin
    if (reset)   q <= rst_val;
    else if (ld) q <= d;
    else         q <= q ^ tog;
  end
endmodule

module t_flipflop_bank #(
  parameter int          WIDTH       = 4,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
`ifdef T_FLIPFLOP_BANK_CHANGED_EN
  output logic             changed,
`endif
  output logic             wrap
);
  localparam logic [WIDTH-1:0] RV = RESET_VALUE[WIDTH-1:0];

  typedef enum logic [1:0] {
    M_TOG  = 2'b00,
    M_LOAD = 2'b01,
    M_UP   = 2'b10,
    M_DOWN = 2'b11
  } mode_e;

  logic [WIDTH-1:0] tog;
  logic             ld;

  // Count modes ripple the toggle enable up through the lower-order bits;
  // t and d are only looked at in their own mode so X elsewhere stays out of q.
  always_comb begin
    tog = '0;
    ld  = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        M_TOG:  tog = t;
        M_LOAD: ld  = 1'b1;
        M_UP: begin
          tog[0] = 1'b1;
          for (int i = 1; i < WIDTH; i++) tog[i] = tog[i-1] & q[i-1];
        end
        M_DOWN: begin
          tog[0] = 1'b1;
          for (int i = 1; i < WIDTH; i++) tog[i] = tog[i-1] & ~q[i-1];
        end
        default: tog = '0;
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    t_flipflop_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .rst_val (RV[g]),
      .tog     (tog[g]),
      .ld      (ld),
      .d       (d[g]),
      .q       (q[g])
    );
  end

  always_comb begin
    tc = 1'b0;
    if (mode == M_UP)   tc = &q;
    if (mode == M_DOWN) tc = ~|q;
  end

  // tc is only ever set in count modes, so an enabled step at tc crosses the terminal.
  always_ff @(posedge clk) begin
    if (reset) wrap <= 1'b0;
    else       wrap <= en & tc;
  end

`ifdef T_FLIPFLOP_BANK_CHANGED_EN
  always_ff @(posedge clk) begin
    if (reset) changed <= 1'b0;
    else       changed <= ld ? (d != q) : |tog;
  end
`endif

endmodule

// File: tb/tb_t_flipflop_bank.sv
// Directed-vector bench for t_flipflop_bank (WIDTH=4, RESET_VALUE 0 and 4'b1001).

module tb_t_flipflop_bank;
  logic       clk = 1'b0;
  logic       reset, en;
  logic [1:0] mode;
  logic [3:0] t, d;
  logic [3:0] q, q2;
  logic       tc, wrap, tc2, wrap2;
`ifdef T_FLIPFLOP_BANK_CHANGED_EN
  logic       chg, chg2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  t_flipflop_bank #(.WIDTH(4), .RESET_VALUE(32'd0)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .t(t), .d(d),
    .q(q), .tc(tc),
`ifdef T_FLIPFLOP_BANK_CHANGED_EN
    .changed(chg),
`endif
    .wrap(wrap)
  );

  t_flipflop_bank #(.WIDTH(4), .RESET_VALUE(32'b1001)) dut_rv (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .t(t), .d(d),
    .q(q2), .tc(tc2),
`ifdef T_FLIPFLOP_BANK_CHANGED_EN
    .changed(chg2),
`endif
    .wrap(wrap2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'b00; t = '0; d = '0;
    #1;
    step(); step();
    reset = 1'b0;
    chk("rst_q", q, 4'b0000);
    chk("rst_wrap", wrap, 0);
    chk("rst_tc", tc, 0);
    chk("rst_q_rv", q2, 4'b1001);

    // toggle mode
    en = 1'b1; mode = 2'b00; t = 4'b0101;
    step(); chk("tog1_q", q, 4'b0101); chk("tog1_q_rv", q2, 4'b1100);
    step(); chk("tog2_q", q, 4'b0000); chk("tog2_q_rv", q2, 4'b1001);

    // load then count up across the terminal value
    mode = 2'b01; d = 4'b1110;
    step(); chk("ld_q", q, 4'b1110); chk("ld_tc", tc, 0);
    mode = 2'b10;
    #1 chk("up0_tc", tc, 0);
    step(); chk("up1_q", q, 4'b1111); chk("up1_tc", tc, 1); chk("up1_wrap", wrap, 0);
    step(); chk("up2_q", q, 4'b0000); chk("up2_wrap", wrap, 1); chk("up2_tc", tc, 0);
    step(); chk("up3_q", q, 4'b0001); chk("up3_wrap", wrap, 0);

    // load then count down across zero
    mode = 2'b01; d = 4'b0001;
    step(); chk("ld2_q", q, 4'b0001);
    mode = 2'b11;
    step(); chk("dn1_q", q, 4'b0000); chk("dn1_tc", tc, 1); chk("dn1_wrap", wrap, 0);
    step(); chk("dn2_q", q, 4'b1111); chk("dn2_wrap", wrap, 1); chk("dn2_tc", tc, 0);
    step(); chk("dn3_q", q, 4'b1110); chk("dn3_wrap", wrap, 0);

    // enable hold during up-count
    mode = 2'b01; d = 4'b0011;
    step();
    mode = 2'b10; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("hold_q", q, 4'b0011); chk("hold_wrap", wrap, 0);
    end
    en = 1'b1;
    step(); chk("resume_q", q, 4'b0100);

    // tc independent of en; no wrap while disabled at terminal
    mode = 2'b01; d = 4'b1111;
    step();
    mode = 2'b10; en = 1'b0;
    step(); chk("hold_tc", tc, 1); chk("hold_term_wrap", wrap, 0); chk("hold_term_q", q, 4'b1111);
    en = 1'b1;
    step(); chk("term_q", q, 4'b0000); chk("term_wrap", wrap, 1);

    // load of 0 / all-ones is not a wrap
    mode = 2'b01; d = 4'b0000;
    step(); chk("ld0_wrap", wrap, 0);

    // X on unused inputs must not reach q
    mode = 2'b00; t = 4'b0000; d = 4'bxxxx;
    step(); chk("xd_q", q, 4'b0000);
    mode = 2'b01; t = 4'bxxxx; d = 4'b1010;
    step(); chk("xt_q", q, 4'b1010);
    t = 4'b0000;

    // reset mid-count overrides en
    mode = 2'b10; reset = 1'b1;
    step(); chk("mid_rst_q", q, 4'b0000); chk("mid_rst_wrap", wrap, 0);
    chk("mid_rst_q_rv", q2, 4'b1001);
    reset = 1'b0;

    // change flag: q starts at 0000
    mode = 2'b01; d = 4'b0110;
    step(); chk("chg_ld_q", q, 4'b0110);
`ifdef T_FLIPFLOP_BANK_CHANGED_EN
    chk("chg_ld1", chg, 1);
`endif
    step();
`ifdef T_FLIPFLOP_BANK_CHANGED_EN
    chk("chg_ld2", chg, 0);
`endif
    mode = 2'b00; t = 4'b0000;
    step(); chk("chg_t0_q", q, 4'b0110);
`ifdef T_FLIPFLOP_BANK_CHANGED_EN
    chk("chg_t0", chg, 0);
`endif
    t = 4'b0001;
    step(); chk("chg_t1_q", q, 4'b0111);
`ifdef T_FLIPFLOP_BANK_CHANGED_EN
    chk("chg_t1", chg, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/t_flipflop_bank.md
Name: t_flipflop_bank

Overview:
- Parametrised successor to the single-bit T flip-flop: a WIDTH-bit register bank built from T-type cells sharing one clock and one reset.
- Four modes: per-bit toggle, parallel load, synchronous up-count and synchronous down-count.
- In both count modes, each cell's toggle input is derived from the lower-order bits.
- Provides terminal-count and wrap indications for cascading, and serves as the general toggle/counter primitive for the lab designs.

Parameters:
- WIDTH, 4, number of T cells (bits); legal range 1..32.
- RESET_VALUE, 0, value loaded into q on reset (WIDTH bits, truncated).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  clock enable; 0 = hold all state.
- mode  input  2  00 toggle, 01 load, 10 count up, 11 count down.
- t  input  WIDTH  per-bit toggle mask (used in mode 00 only).
- d  input  WIDTH  parallel load data (used in mode 01 only).
- q  output  WIDTH  registered bank state.
- tc  output  1  terminal count, combinational from q and mode.
- wrap  output  1  registered one-cycle wrap pulse.

Behaviour:
- One clock: clk. Reset is synchronous and active-high: on a rising clk edge with reset=1, q <= RESET_VALUE and wrap <= 0. Reset overrides en, mode and all data inputs.
- Reset mid-operation (any mode, any count value) takes effect at the next edge; there is no partial update.
- All state updates occur on the rising edge of clk; q has 1-cycle latency from inputs.
- en=0 (no reset): q holds, wrap <= 0.
- en=1, mode 00: q <= q ^ t. t=0 holds; t=all-ones inverts every bit.
- en=1, mode 01: q <= d.
- en=1, mode 10: q <= q + 1 mod 2^WIDTH.
  - Implemented as T cells: bit 0 toggles every cycle; bit i toggles when q[i-1:0] is all ones.
  - From all-ones, q wraps to 0.
- en=1, mode 11: q <= q - 1 mod 2^WIDTH.
  - Bit 0 toggles every cycle; bit i toggles when q[i-1:0] is all zeros.
  - From 0, q wraps to all-ones.
- tc (combinational):
  - tc = 1 when mode=10 and q=all-ones.
  - tc = 1 when mode=11 and q=0.
  - tc = 0 in modes 00/01. tc does not depend on en.
- wrap (registered):
  - wrap <= 1 for exactly one cycle when an enabled count-mode update moves q across the terminal value (up: all-ones->0; down: 0->all-ones).
  - wrap <= 0 otherwise, including a load or toggle that happens to produce 0 or all-ones.
- Mode change takes effect on the same edge it is sampled. A count from a loaded value starts on the edge after the load.
- WIDTH=1:
  - Up and down modes both toggle q every enabled cycle.
  - tc follows the rules above, using a 1-bit all-ones / zero.
- X on t/d in an unused mode must not propagate to q.

Optional Feature:
- Macro: T_FLIPFLOP_BANK_CHANGED_EN.
- When defined:
  - Extra output port changed (1 bit), registered.
  - changed <= 1 on any edge where the new q differs from the current q; otherwise 0.
  - Reset drives changed <= 0.
  - A toggle with t=0 or a load of d equal to q gives changed=0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=4, reset=1 for 2 edges, then 0 -> q=0000, wrap=0, tc=0 (mode 00). Then en=1, mode 00, t=0101 for 2 edges -> q=0101, then 0000.
- mode 01, d=1110, 1 edge; then mode 10 for 3 edges -> q=1110, 1111 (tc=1), 0000 (wrap=1 this cycle only), 0001 (wrap=0).
- mode 01, d=0001; then mode 11 for 3 edges -> q=0000 (tc=1), 1111 (wrap=1), 1110 (wrap=0, tc=0).
- mode 10 counting from 0011, en=0 for 3 edges then en=1 -> q holds 0011 with wrap=0 throughout, then 0100.
- mode 10 at q=1010, reset=1 with en=1 on one edge -> q=0000 (RESET_VALUE), wrap=0. Repeat with RESET_VALUE=4'b1001 -> q=1001.
- With T_FLIPFLOP_BANK_CHANGED_EN: load 0110, then load 0110 again -> changed=1, then 0. Then toggle t=0000 -> changed=0. Then toggle t=0001 -> q=0111, changed=1.
